// File: rtl/regblock_seq.sv
// Multicycle sequencer for the RegBlock register-file/ALU datapath.
// Flow: IDLE -> DECODE -> EXEC -> WB, or DECODE -> HALTED for the HALT opcode.
module regblock_seq #(
  parameter int RWIDTH = 6,
  parameter int DWIDTH = 32,
  parameter int IMM_IN = 15,
  parameter int CWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DWIDTH-1:0] instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [DWIDTH-1:0] ALUresult,
  output logic [RWIDTH-1:0] rs,
  output logic [RWIDTH-1:0] rt,
  output logic [RWIDTH-1:0] rd,
  output logic [IMM_IN-1:0] imm_in,
  output logic              muxsel1,
  output logic [3:0]        ALUopsel,
  output logic [DWIDTH-1:0] wd,
  output logic              we,
  output logic              busy,
  output logic              halted,
  output logic [CWIDTH-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALTED = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [DWIDTH-1:0]   ir_q, ir_d;
  logic [DWIDTH-1:0]   wd_q, wd_d;
  logic [CWIDTH-1:0]   retired_q, retired_d;
  logic                we_q, we_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                halted_q, halted_d;
  logic                is_halt_s;
  logic                rd_zero_s;

  assign is_halt_s = ir_q[31] & (ir_q[30:27] == 4'hF);
  assign rd_zero_s = (ir_q[21 +: RWIDTH] == {RWIDTH{1'b0}});

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ir_q      <= {DWIDTH{1'b0}};
      wd_q      <= {DWIDTH{1'b0}};
      retired_q <= {CWIDTH{1'b0}};
      we_q      <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      wd_q      <= wd_d;
      retired_q <= retired_d;
      we_q      <= we_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
    end
  end

  // Next state and instruction capture.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DECODE: begin
        if (is_halt_s) begin
          state_d = S_HALTED;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = S_IDLE;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  // Registered outputs, derived from the upcoming state so they line up with it.
  always_comb begin
    ready_d   = (state_d == S_IDLE);
    busy_d    = (state_d == S_DECODE) | (state_d == S_EXEC) | (state_d == S_WB);
    halted_d  = (state_d == S_HALTED);
    we_d      = (state_d == S_WB) & ~rd_zero_s;
    if (state_q == S_EXEC) begin
      wd_d = ALUresult;
    end else begin
      wd_d = wd_q;
    end
    if (state_q == S_WB) begin
      retired_d = retired_q + CWIDTH'(1);
    end else begin
      retired_d = retired_q;
    end
  end

  assign muxsel1     = ir_q[31];
  assign ALUopsel    = ir_q[30:27];
  assign rd          = ir_q[21 +: RWIDTH];
  assign rs          = ir_q[15 +: RWIDTH];
  assign rt          = ir_q[9 +: RWIDTH];
  assign imm_in      = ir_q[IMM_IN-1:0];
  assign wd          = wd_q;
  assign we          = we_q;
  assign instr_ready = ready_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_regblock_seq.sv
// Bench for regblock_seq: table vectors, directed corner sequences and random
// instructions, all checked every cycle against a cycle-count based reference.
module tb_regblock_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] alu_in;
  logic        instr_ready, muxsel1, we, busy, halted;
  logic [5:0]  rs, rt, rd;
  logic [14:0] imm_in;
  logic [3:0]  ALUopsel;
  logic [31:0] wd;
  logic [15:0] retired;
  logic        w_ready, w_mux, w_we, w_busy, w_halted;
  logic [5:0]  w_rs, w_rt, w_rd;
  logic [14:0] w_imm;
  logic [3:0]  w_op;
  logic [31:0] w_wd;
  logic [1:0]  w_retired;

  regblock_seq dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .ALUresult(alu_in), .rs(rs), .rt(rt), .rd(rd),
    .imm_in(imm_in), .muxsel1(muxsel1), .ALUopsel(ALUopsel), .wd(wd), .we(we),
    .busy(busy), .halted(halted), .retired(retired)
  );

  // Narrow-counter instance to exercise the all-ones to zero wrap.
  regblock_seq #(.CWIDTH(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(w_ready), .ALUresult(alu_in), .rs(w_rs), .rt(w_rt), .rd(w_rd),
    .imm_in(w_imm), .muxsel1(w_mux), .ALUopsel(w_op), .wd(w_wd), .we(w_we),
    .busy(w_busy), .halted(w_halted), .retired(w_retired)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Reference: an instruction accepted at edge count m_acc is in flight for
  // three cycles; write-back is the third, HALT freezes after the first.
  int          cyc = 0;
  int          m_acc = 0;
  bit          m_pend, m_halt;
  logic [31:0] m_ir, m_wd, m_alu;
  int          m_ret;
  int          acc_log[$];

  typedef struct {
    logic [31:0] ins;
    logic [31:0] alu;
    logic        exp_mux;
    logic [14:0] exp_imm;
    int          exp_we;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    m_pend = 1'b0; m_halt = 1'b0; m_ir = 32'd0; m_wd = 32'd0; m_ret = 0;
  endtask

  task automatic cmp_all();
    int   since;
    logic exp_we;
    since  = cyc - m_acc;
    exp_we = m_pend && (since == 2) && (m_ir[26:21] != 6'd0);
    chk("instr_ready", instr_ready, !m_halt && !m_pend);
    chk("busy", busy, m_pend);
    chk("halted", halted, m_halt);
    chk("we", we, exp_we);
    chk("wd", wd, m_wd);
    chk("retired", retired, m_ret[15:0]);
    chk("retired_wrap", w_retired, m_ret[1:0]);
    chk("muxsel1", muxsel1, m_ir[31]);
    chk("ALUopsel", ALUopsel, m_ir[30:27]);
    chk("rd", rd, m_ir[26:21]);
    chk("rs", rs, m_ir[20:15]);
    chk("rt", rt, m_ir[14:9]);
    chk("imm_in", imm_in, m_ir[14:0]);
  endtask

  task automatic tick();
    bit idle;
    int since;
    @(posedge clk);
    idle = !m_halt && !m_pend;
    cyc++;
    if (idle && instr_valid) begin
      m_pend = 1'b1; m_acc = cyc; m_ir = instr; m_alu = alu_in;
      acc_log.push_back(cyc);
    end else if (m_pend) begin
      since = cyc - m_acc;
      if (since == 1 && m_ir[31] && m_ir[30:27] == 4'hF) begin
        m_halt = 1'b1; m_pend = 1'b0;
      end else if (since == 2) begin
        m_wd = m_alu;
      end else if (since == 3) begin
        m_ret++; m_pend = 1'b0;
      end
    end
    #1;
    alu_in = (m_pend && (cyc - m_acc) == 1) ? m_alu : ~m_alu;
    cmp_all();
  endtask

  task automatic do_reset();
    #2;
    instr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    cmp_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_accept(input logic [31:0] ins, input logic [31:0] alu);
    bit got = 1'b0;
    instr = ins; alu_in = alu; instr_valid = 1'b1;
    for (int k = 0; k < 10 && !got; k++) begin
      tick();
      if (m_pend && cyc == m_acc) got = 1'b1;
    end
    if (!got) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain(output int we_cnt);
    we_cnt = 0;
    for (int k = 0; k < 10 && m_pend; k++) begin
      tick();
      if (we) we_cnt++;
    end
    if (m_pend) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] alu, output int we_cnt);
    wait_accept(ins, alu);
    instr_valid = 1'b0;
    alu_in = ~alu;
    drain(we_cnt);
  endtask

  initial begin
    vec_t        vt[4];
    int          wc, r0;
    logic [31:0] ins;

    vt[0] = '{{1'b0, 4'h2, 6'h3F, 6'h23, 6'h29, 9'h000}, 32'hFFAAFFAA, 1'b0, 15'h5200, 1};
    vt[1] = '{{1'b1, 4'h3, 6'h0C, 6'h05, 15'h1FFF}, 32'h12345678, 1'b1, 15'h1FFF, 1};
    vt[2] = '{{1'b0, 4'h1, 6'h00, 6'h07, 6'h08, 9'h000}, 32'hDEADBEEF, 1'b0, 15'h1000, 0};
    vt[3] = '{{1'b1, 4'hE, 6'h00, 6'h3F, 15'h7FFF}, 32'h0000FFFF, 1'b1, 15'h7FFF, 0};

    instr = 32'd0; instr_valid = 1'b0; alu_in = 32'd0; rst_n = 1'b1;
    model_reset();
    do_reset();

    for (int i = 0; i < 4; i++) begin
      r0 = m_ret;
      send(vt[i].ins, vt[i].alu, wc);
      chk("tbl_we_pulses", wc, vt[i].exp_we);
      chk("tbl_wd", wd, vt[i].alu);
      chk("tbl_muxsel1", muxsel1, vt[i].exp_mux);
      chk("tbl_imm_in", imm_in, vt[i].exp_imm);
      chk("tbl_retired", retired, 16'(r0 + 1));
    end

    // Reset in the middle of EXEC.
    wait_accept(32'h1234_5678, 32'hCAFE_F00D);
    instr_valid = 1'b0;
    tick();
    do_reset();
    tick();
    chk("ready_after_reset", instr_ready, 1'b1);

    // Reset during WB must kill the write and the retire.
    wait_accept({1'b0, 4'h4, 6'h11, 6'h02, 6'h03, 9'h000}, 32'h0BAD_0BAD);
    instr_valid = 1'b0;
    tick(); tick();
    chk("we_before_reset", we, 1'b1);
    do_reset();
    chk("we_in_reset", we, 1'b0);
    tick();
    chk("retired_after_wb_reset", retired, 16'd0);

    // Back-to-back with instr_valid held high.
    acc_log.delete();
    for (int i = 0; i < 3; i++) wait_accept({1'b0, 4'(i), 6'(i + 1), 6'h01, 6'h02, 9'h000}, 32'(i * 7 + 1));
    instr_valid = 1'b0;
    drain(wc);
    chk("b2b_gap1", acc_log[1] - acc_log[0], 4);
    chk("b2b_gap2", acc_log[2] - acc_log[1], 4);
    chk("b2b_retired", retired, 16'd3);

    // Random instructions with random gaps; HALT encodings excluded.
    for (int i = 0; i < 24; i++) begin
      ins = $urandom;
      if (ins[31] && ins[30:27] == 4'hF) ins[30:27] = 4'hE;
      repeat ($urandom_range(0, 2)) tick();
      send(ins, $urandom, wc);
    end
    chk("rand_retired", retired, 16'd27);

    // HALT, then keep offering an instruction.
    r0 = m_ret;
    wait_accept({1'b1, 4'hF, 6'h05, 6'h06, 15'h0007}, 32'h5555_AAAA);
    tick();
    chk("halted_one_after", halted, 1'b1);
    instr = {1'b0, 4'h2, 6'h09, 6'h01, 6'h02, 9'h000};
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("halt_no_ready", instr_ready, 1'b0);
      chk("halt_no_we", we, 1'b0);
    end
    chk("halt_retired", retired, 16'(r0));
    do_reset();
    chk("halt_cleared", halted, 1'b0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
